nibble_serial_subtractor: RTL and testbench



---
 rtl/nibble_serial_subtractor.sv | 159 +++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// ---------------------------------------------------------------------------
// nibble_serial_subtractor
//
// Multi-cycle subtractor D = A - B - Bin. One 4-bit slice is processed per
// clock, least significant first. The borrow is held in a register between
// slices. There is a valid/ready handshake on both input and output, and only
// one operation is in flight at a time.
//
// Optional feature (macro NIBBLE_SUB_ADD_MODE_EN): adds an Op input. Op is
// latched with the operands. Op = 1 computes D = A + B + Bin, with Bout then
// reporting carry out and Ovf reporting signed add overflow.
//
// Parameters:
//   WIDTH      operand/result width, a multiple of 4 and at least 4
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands present
//   in_ready   block can accept operands (IDLE and not in reset)
//   A, B, Bin  minuend, subtrahend, borrow in
//   Op         (feature only) 1 = add, 0 = subtract
//   out_valid  result present (DONE state)
//   out_ready  consumer takes result
//   D          registered difference (or sum)
//   Bout       borrow out (unsigned A < B + Bin), or carry out in add mode
//   Ovf        signed overflow of the full-width result
//   Zero       D == 0, only asserted while out_valid is high
// ---------------------------------------------------------------------------
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
`ifdef NIBBLE_SUB_ADD_MODE_EN
  input  logic             Op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             borrow_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             op_p0;
  logic [WIDTH-1:0] d_p1;
  logic             bout_p1;
  logic             ovf_p1;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [5:0]       slice_res;

  // One slice. It returns {msb_ovf, carry/borrow out, 4-bit result}.
  // The 3-bit partial operation gives the carry/borrow into bit 3.
  // XOR with the carry/borrow out of bit 3 is the signed overflow. That value
  // is only used on the most significant slice.
  function automatic logic [5:0] slice_op(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic       c,
                                          input logic       op);
    logic [3:0] lo;
    logic [4:0] full;
    if (op) begin
      lo   = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, c};
      full = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    end else begin
      lo   = {1'b0, a[2:0]} - {1'b0, b[2:0]} - {3'b000, c};
      full = {1'b0, a} - {1'b0, b} - {4'b0000, c};
    end
    return {lo[3] ^ full[4], full};
  endfunction

  // Stage p0: latched operands, slice index and running borrow
  assign a_nib     = a_p0[{idx_p0, 2'b00} +: 4];
  assign b_nib     = b_p0[{idx_p0, 2'b00} +: 4];
  assign slice_res = slice_op(a_nib, b_nib, borrow_p0, op_p0);

`ifdef NIBBLE_SUB_ADD_MODE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0 <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      op_p0 <= Op;
    end
  end
`else
  assign op_p0 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_p0      <= '0;
      b_p0      <= '0;
      borrow_p0 <= 1'b0;
      idx_p0    <= '0;
      d_p1      <= '0;
      bout_p1   <= 1'b0;
      ovf_p1    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_p0      <= A;
            b_p0      <= B;
            borrow_p0 <= Bin;
            idx_p0    <= '0;
            state     <= RUN;
          end
        end
        // Stage p1: result nibbles and final flags
        RUN: begin
          d_p1[{idx_p0, 2'b00} +: 4] <= slice_res[3:0];
          borrow_p0 <= slice_res[4];
          idx_p0    <= idx_p0 + 1'b1;
          if (idx_p0 == LAST_IDX) begin
            bout_p1 <= slice_res[4];
            ovf_p1  <= slice_res[5];
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is gated by rst_n so that it drops while reset is held.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign D         = d_p1;
  assign Bout      = bout_p1;
  assign Ovf       = ovf_p1;
  // Gating with out_valid keeps Zero at 0 out of reset.
  assign Zero      = out_valid && (d_p1 == '0);

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

  localparam int W       = 16;
  localparam int NIB     = W / 4;
  localparam int TIMEOUT = 50;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
`ifdef NIBBLE_SUB_ADD_MODE_EN
  logic         Op;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         Ovf;
  logic         Zero;

  int total;
  int bad;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
`ifdef NIBBLE_SUB_ADD_MODE_EN
    .Op        (Op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .Ovf       (Ovf),
    .Zero      (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the full-width operands.
  // Returns {zero, ovf, bout, d}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin, input logic op);
    int ua, ub, sa, sb, ru, rs;
    logic [W-1:0] d;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op) begin
      ru = ua + ub + int'(bin);
      rs = sa + sb + int'(bin);
      bo = (ru > (1 << W) - 1);
    end else begin
      ru = ua - ub - int'(bin);
      rs = sa - sb - int'(bin);
      bo = (ru < 0);
    end
    ov = (rs < -(1 << (W - 1))) || (rs > (1 << (W - 1)) - 1);
    d  = ru[W-1:0];
    return {(d == '0), ov, bo, d};
  endfunction

  // Run one full transaction. hold = number of DONE cycles with out_ready low.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input logic op, input int hold);
    logic [W+2:0] exp;
    int n;
    n = 0;
    while (!in_ready && n < TIMEOUT) begin tick(); n++; end
    chk({tag, ".in_ready"}, in_ready, 1);
    A = a; B = b; Bin = bin;
`ifdef NIBBLE_SUB_ADD_MODE_EN
    Op = op;
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    n = 0;
    while (!out_valid && n < TIMEOUT) begin tick(); n++; end
    chk({tag, ".latency"}, n, NIB);
    exp = model(a, b, bin, op);
    chk({tag, ".D"}, D, exp[W-1:0]);
    chk({tag, ".Bout"}, Bout, exp[W]);
    chk({tag, ".Ovf"}, Ovf, exp[W+1]);
    chk({tag, ".Zero"}, Zero, exp[W+2]);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      A = W'($urandom); B = W'($urandom);
      tick();
      chk({tag, ".hold_vld"}, out_valid, 1);
      chk({tag, ".hold_rdy"}, in_ready, 0);
      chk({tag, ".hold_D"}, D, exp[W-1:0]);
      chk({tag, ".hold_flags"}, {Zero, Ovf, Bout}, exp[W+2:W]);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".drop_vld"}, out_valid, 0);
    chk({tag, ".idle_rdy"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rbin;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
`ifdef NIBBLE_SUB_ADD_MODE_EN
    Op = 1'b0;
`endif
    tick();
    tick();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.D", D, 0);
    chk("rst.flags", {Zero, Ovf, Bout}, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst.in_ready", in_ready, 1);

    run_op("t1", 16'h1234, 16'h0234, 1'b0, 1'b0, 0);
    run_op("t2", 16'h0000, 16'h0001, 1'b0, 1'b0, 0);
    run_op("t3", 16'h8000, 16'h0001, 1'b0, 1'b0, 0);
    run_op("t4", 16'h0005, 16'h0004, 1'b1, 1'b0, 0);
    run_op("t5", 16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    run_op("bp", 16'h4321, 16'h1234, 1'b1, 1'b0, 6);

    // Reset in the middle of RUN, during slice 2
    A = 16'h5555; B = 16'h1111; Bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", out_valid, 0);
    chk("mid_rst.in_ready", in_ready, 0);
    chk("mid_rst.D", D, 0);
    chk("mid_rst.flags", {Zero, Ovf, Bout}, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b1;
      tick();
      chk("mid_rst.no_vld", out_valid, 0);
    end
    out_ready = 1'b0;
    run_op("after_rst", 16'hABCD, 16'h1111, 1'b0, 1'b0, 0);

`ifdef NIBBLE_SUB_ADD_MODE_EN
    run_op("add1", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 0);
    run_op("add2", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 0);
`endif

    for (int k = 0; k < 24; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op("rand", ra, rb, rbin, 1'($urandom_range(0, 1) & 0), $urandom_range(0, 2));
`ifdef NIBBLE_SUB_ADD_MODE_EN
      run_op("rand_add", ra, rb, rbin, 1'b1, 0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
